// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared constants for the bit-serial adder/subtractor:
//   FSM state encoding and the operation-mode encoding of the 'mode' input.
package serial_addsub_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_bit_FA.sv
// bit_FA
//   One-bit full adder assembled from two half-adder cells and an OR gate.
//   Ports:
//     A, B   in  1  addend bits
//     Cin    in  1  carry in
//     SUM    out 1  sum bit
//     Carry  out 1  carry out
module bit_FA (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic SUM,
   output logic Carry
);

   logic ha0_s, ha0_c;
   logic ha1_s, ha1_c;

   // first half adder: A + B
   assign ha0_s = A ^ B;
   assign ha0_c = A & B;

   // second half adder: partial sum + Cin
   assign ha1_s = ha0_s ^ Cin;
   assign ha1_c = ha0_s & Cin;

   // the two half-adder carries can never both be 1, so OR suffices
   assign SUM   = ha1_s;
   assign Carry = ha0_c | ha1_c;

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder/subtractor. Operands are loaded on an accepted start and
//   processed LSB first, one bit per clock, through a single full-adder cell.
//   Result, carry-out and signed overflow are published together with a
//   one-cycle done pulse WIDTH clocks after the accepting edge.
//   Ports:
//     clk       in  1      clock, rising edge
//     rst_n     in  1      synchronous active-low reset
//     start     in  1      request, honoured only in IDLE or DONE
//     mode      in  1      0 = A+B, 1 = A-B (sampled with start)
//     A, B      in  WIDTH  operands (sampled with start)
//     busy      out 1      high while bits are being processed
//     done      out 1      one-cycle completion pulse
//     SUM       out WIDTH  result, held until the next completion
//     Carry     out 1      carry out of MSB (subtract: 1 = no borrow)
//     Overflow  out 1      two's-complement overflow
import serial_addsub_pkg::*;

module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] SUM,
   output logic             Carry,
   output logic             Overflow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] opa_reg, opb_reg, res_reg;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg, ovf_reg;

   logic accept, last_bit;
   logic fa_s, fa_co;

   assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign last_bit = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

   bit_FA u_fa (
      .A     (opa_reg[0]),
      .B     (opb_reg[0]),
      .Cin   (carry_reg),
      .SUM   (fa_s),
      .Carry (fa_co)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start)    state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // outputs follow the state directly
   always_comb begin
      busy = (state_reg == ST_RUN);
      done = (state_reg == ST_DONE);
   end

   // datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opa_reg   <= '0;
         opb_reg   <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         opa_reg   <= A;
         // subtract as A + ~B + 1: invert B and seed the carry with 1
         opb_reg   <= (mode == MODE_SUB) ? ~B : B;
         carry_reg <= (mode == MODE_SUB);
         cnt_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
         opa_reg   <= {1'b0, opa_reg[WIDTH-1:1]};
         opb_reg   <= {1'b0, opb_reg[WIDTH-1:1]};
         res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
         carry_reg <= fa_co;
         cnt_reg   <= cnt_reg + CNT_W'(1);
         if (last_bit) begin
            // carry_reg here is the carry into the MSB
            sum_reg  <= {fa_s, res_reg[WIDTH-1:1]};
            cout_reg <= fa_co;
            ovf_reg  <= carry_reg ^ fa_co;
         end
      end
   end

   assign SUM      = sum_reg;
   assign Carry    = cout_reg;
   assign Overflow = ovf_reg;

endmodule
